// File: rtl/ucsbece152a_step_pkg.sv
// Shared types and helpers for the step/direction button front-end.
package ucsbece152a_step_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } step_state_t;

    // Bits needed to count up to the larger of the two repeat intervals.
    function automatic int timer_width(input int delay, input int period);
        int m;
        m = (delay > period) ? delay : period;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Bits needed for a debounce counter reaching n.
    function automatic int count_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ucsbece152a_debounce.sv
// Two-flop synchronizer, stable-count debouncer and registered rise detect
// for one raw push-button.
module ucsbece152a_debounce
    import ucsbece152a_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = count_width(DEBOUNCE_CYCLES);
    localparam int LAST_I = DEBOUNCE_CYCLES - 1;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw_i;
            sync_2 <= sync_1;
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_2 != level) begin
            if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered one-cycle pulse on each debounced rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            rise_o  <= 1'b0;
        end else begin
            level_d <= level;
            rise_o  <= level & ~level_d;
        end
    end

    assign level_o = level;

endmodule

// File: rtl/ucsbece152a_step_ctrl.sv
// Button front-end for the up/down counter: step pulses with auto-repeat
// and a direction level toggled by a second button.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for a debounced step press (also held state when repeat is off)
//   S_DELAY  | first pulse issued, counting the hold time before repeat starts
//   S_REPEAT | auto-repeating, one pulse every REPEAT_PERIOD cycles
module ucsbece152a_step_ctrl
    import ucsbece152a_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_btn_i,
    input  logic dir_btn_i,
    output logic enable_o,
    output logic dir_o,
    output logic held_o
);

    localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int DELAY_LAST_I  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int PERIOD_LAST_I = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;
    localparam logic [TW-1:0] DELAY_LAST  = DELAY_LAST_I[TW-1:0];
    localparam logic [TW-1:0] PERIOD_LAST = PERIOD_LAST_I[TW-1:0];
    localparam logic REPEAT_ON = (REPEAT_DELAY > 0);

    logic          step_level;
    logic          step_rise;
    logic          dir_level;
    logic          dir_rise;
    logic          dir_level_q;

    step_state_t   state;
    step_state_t   state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          enable;

    ucsbece152a_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (step_btn_i),
        .level_o (step_level),
        .rise_o  (step_rise)
    );

    ucsbece152a_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (dir_btn_i),
        .level_o (dir_level),
        .rise_o  (dir_rise)
    );

    // Step FSM state and repeat timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state, timer and step pulse decode; release has priority over a pulse.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        enable    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (step_rise) begin
                    enable    = 1'b1;
                    state_nxt = REPEAT_ON ? S_DELAY : S_IDLE;
                end
            end
            S_DELAY: begin
                if (!step_level) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (timer == DELAY_LAST) begin
                    enable    = 1'b1;
                    timer_nxt = '0;
                    state_nxt = S_REPEAT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!step_level) begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end else if (timer == PERIOD_LAST) begin
                    enable    = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Direction toggle. Edge-detected from the debounced level here (rather than
    // from the registered dir_rise) so dir_o flips on the same edge that the
    // step pulse rises, letting a simultaneous step use the new direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_level_q <= 1'b0;
            dir_o       <= 1'b0;
        end else begin
            dir_level_q <= dir_level;
            if (dir_level && !dir_level_q) begin
                dir_o <= ~dir_o;
            end
        end
    end

    assign enable_o = enable;
    assign held_o   = step_level;

    // The registered dir rise is unused by the top; keep it observable for lint.
    logic unused_dir_rise;
    assign unused_dir_rise = dir_rise;

endmodule

// File: tb/tb_ucsbece152a_step_ctrl.sv
// Directed bench for the step/direction front-end. Two instances share the
// buttons: u0 with defaults (repeat on), u1 with auto-repeat disabled.
module tb_ucsbece152a_step_ctrl;

    logic clk;
    logic rst_n;
    logic step_btn;
    logic dir_btn;
    logic en0, dir0, held0;
    logic en1, dir1, held1;

    int errors;
    int checks;
    int cyc;
    int q0[$];
    int q1[$];

    ucsbece152a_step_ctrl u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_btn_i (step_btn),
        .dir_btn_i  (dir_btn),
        .enable_o   (en0),
        .dir_o      (dir0),
        .held_o     (held0)
    );

    ucsbece152a_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (0),
        .REPEAT_PERIOD   (3)
    ) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_btn_i (step_btn),
        .dir_btn_i  (dir_btn),
        .enable_o   (en1),
        .dir_o      (dir1),
        .held_o     (held1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock and score both enable outputs against the expected-pulse queues.
    task automatic tick();
        logic exp0;
        logic exp1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp0 = 1'b0;
        exp1 = 1'b0;
        if (q0.size() > 0 && q0[0] <= cyc) begin
            exp0 = (q0[0] == cyc);
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0] <= cyc) begin
            exp1 = (q1[0] == cyc);
            void'(q1.pop_front());
        end
        if (en0 || exp0) chk("u0_enable", en0, exp0);
        if (en1 || exp1) chk("u1_enable", en1, exp1);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk_drained(input string tag);
        chk_int({tag, "_q0_left"}, q0.size(), 0);
        chk_int({tag, "_q1_left"}, q1.size(), 0);
    endtask

    initial begin
        int k;
        int s;
        int m;
        logic dir_exp;

        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        step_btn = 1'b0;
        dir_btn  = 1'b0;
        dir_exp  = 1'b0;

        // Reset state
        #1;
        chk("rst_en0", en0, 1'b0);
        chk("rst_dir0", dir0, 1'b0);
        chk("rst_held0", held0, 1'b0);
        chk("rst_en1", en1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_to(5);

        // 1. Clean press held 6 cycles
        k = cyc;
        q0.push_back(k + 7);
        q1.push_back(k + 7);
        step_btn = 1'b1;
        run_to(k + 5);
        chk("t1_held_before", held0, 1'b0);
        run_to(k + 6);
        chk("t1_held_rise", held0, 1'b1);
        step_btn = 1'b0;
        run_to(k + 11);
        chk("t1_held_still", held0, 1'b1);
        run_to(k + 12);
        chk("t1_held_fall", held0, 1'b0);
        run_to(k + 30);
        chk_drained("t1");

        // 2. Bouncy press then steady
        step_btn = 1'b1; tick();
        step_btn = 1'b0; tick();
        step_btn = 1'b1; tick();
        step_btn = 1'b0; tick();
        s = cyc;
        q0.push_back(s + 7);
        q1.push_back(s + 7);
        step_btn = 1'b1;
        run_to(s + 6);
        step_btn = 1'b0;
        run_to(s + 30);
        chk_drained("t2");

        // 3. Step held 40 cycles: first pulse, delayed pulse, then period-3 repeat
        k = cyc;
        q0.push_back(k + 7);
        q0.push_back(k + 15);
        for (int t = k + 18; t <= k + 45; t += 3) q0.push_back(t);
        q1.push_back(k + 7);
        step_btn = 1'b1;
        run_to(k + 40);
        step_btn = 1'b0;
        run_to(k + 60);
        chk_drained("t3");

        // 4. Three direction presses
        for (int i = 0; i < 3; i++) begin
            k = cyc;
            dir_btn = 1'b1;
            run_to(k + 6);
            chk("t4_dir_before", dir0, dir_exp);
            run_to(k + 7);
            dir_exp = ~dir_exp;
            chk("t4_dir_after", dir0, dir_exp);
            chk("t4_dir_after_u1", dir1, dir_exp);
            run_to(k + 8);
            dir_btn = 1'b0;
            run_to(k + 20);
        end
        chk_drained("t4");

        // 5. Step and direction together
        k = cyc;
        q0.push_back(k + 7);
        q1.push_back(k + 7);
        step_btn = 1'b1;
        dir_btn  = 1'b1;
        run_to(k + 6);
        chk("t5_dir_before", dir0, dir_exp);
        run_to(k + 7);
        dir_exp = ~dir_exp;
        chk("t5_dir_with_en", dir0, dir_exp);
        chk("t5_en_with_dir", en0, 1'b1);
        run_to(k + 8);
        step_btn = 1'b0;
        dir_btn  = 1'b0;
        run_to(k + 25);
        chk_drained("t5");

        // 6. Reset mid-repeat while held, then release
        k = cyc;
        dir_btn = 1'b1;
        run_to(k + 8);
        dir_btn = 1'b0;
        run_to(k + 20);
        dir_exp = ~dir_exp;
        chk("t6_dir_set", dir0, dir_exp);
        k = cyc;
        q0.push_back(k + 7);
        q0.push_back(k + 15);
        q0.push_back(k + 18);
        q1.push_back(k + 7);
        step_btn = 1'b1;
        run_to(k + 20);
        @(posedge clk);
        #1;
        chk("t6_en_pulse", en0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en0", en0, 1'b0);
        chk("t6_rst_dir0", dir0, 1'b0);
        chk("t6_rst_held0", held0, 1'b0);
        chk("t6_rst_en1", en1, 1'b0);
        @(negedge clk);
        cyc++;
        tick();
        tick();
        tick();
        m = cyc;
        q0.push_back(m + 7);
        q1.push_back(m + 7);
        rst_n = 1'b1;
        run_to(m + 6);
        chk("t6_held_again", held0, 1'b1);
        step_btn = 1'b0;
        run_to(m + 25);
        chk_drained("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
